vend_ctrl_multi: RTL and testbench

//  Parametrised successor to the single-product vending control FSM.
//  - Supports NUM_ITEMS products, each with its own stock counter.
//  - Prices rise by one unit when an item's stock is low.
//  - Supports a cancel/refund path.
//  - Pays change out one coin at a time through a valid/ack handshake.
//  - Sits between the debounced button/coin front end and the display, LED and audio blocks.

---
 rtl/vend_pkg.sv | 39 +++
 rtl/vend_stock_bank.sv | 47 ++++
 rtl/vend_ctrl_multi.sv | 193 +++++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package vend_pkg;

    // FSM state encoding; values are visible on the debug/display port
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_VEND      = 3'd2,
        S_CHANGE    = 3'd3,
        S_THANK_YOU = 3'd4,
        S_ERROR     = 3'd5,
        S_REFUND    = 3'd6
    } state_t;

    // Change denominations, largest first
    localparam int unsigned DENOM_HI  = 5;
    localparam int unsigned DENOM_MID = 2;
    localparam int unsigned DENOM_LO  = 1;

    // Base price table; item indices beyond 3 wrap onto it modulo 4
    function automatic logic [3:0] base_of(input logic [1:0] idx);
        logic [3:0] b;
        case (idx)
            2'd0:    b = 4'd3;
            2'd1:    b = 4'd4;
            2'd2:    b = 4'd6;
            default: b = 4'd8;
        endcase
        return b;
    endfunction

    // A low-stock item costs one unit more than its base price
    function automatic logic [4:0] price_of(input logic [3:0] base, input logic low);
        return {1'b0, base} + {4'b0000, low};
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with restock, single-item decrement and low-stock flags.
// Latency: counters update on the clock edge; read ports and low flags are combinational.
// Backpressure: none; a decrement of an empty counter is ignored and restock has priority.
module vend_stock_bank #(
    parameter int NUM_ITEMS  = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 5,
    parameter int STOCK_MAX  = 15,
    parameter int LOW_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dec_stb,
    input  logic [$clog2(NUM_ITEMS)-1:0] op_idx,
    input  logic                         restock,
    input  logic [$clog2(NUM_ITEMS)-1:0] rd_idx,
    output logic [STOCK_W-1:0]           rd_level,
    output logic [STOCK_W-1:0]           op_level,
    output logic [NUM_ITEMS-1:0]         low
);

    logic [STOCK_W-1:0] stock [NUM_ITEMS];

    // Counter update: reset to initial fill, restock to full, or take one item
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (restock) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_MAX);
        end else if (dec_stb && stock[op_idx] != '0) begin
            stock[op_idx] <= stock[op_idx] - STOCK_W'(1);
        end
    end

    // Read muxes for the display (rd) and the controller's latched item (op)
    always_comb begin
        rd_level = stock[rd_idx];
        op_level = stock[op_idx];
    end

    // Low-stock flags drive the price bump and the front-panel LEDs
    always_comb begin
        low = '0;
        for (int i = 0; i < NUM_ITEMS; i++) low[i] = (stock[i] <= STOCK_W'(LOW_THRESH));
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit, price check, vend, refund and coin-by-coin change.
// Latency: purchase -> CHECK next cycle -> VEND/ERROR the cycle after; outputs are registered.
// Backpressure: each change coin holds chg_valid/chg_value until chg_ack; one idle cycle between coins.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS        = 4,
    parameter int CREDIT_W         = 8,
    parameter int STOCK_W          = 4,
    parameter int STOCK_INIT       = 5,
    parameter int STOCK_MAX        = 15,
    parameter int LOW_THRESH       = 2,
    parameter int THANK_YOU_CYCLES = 100000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_valid,
    input  logic [CREDIT_W-1:0]          coin_value,
    input  logic                         purchase,
    input  logic                         cancel,
    input  logic [$clog2(NUM_ITEMS)-1:0] item_sel,
    input  logic                         restock,
    output logic                         chg_valid,
    output logic [CREDIT_W-1:0]          chg_value,
    input  logic                         chg_ack,
    output logic [CREDIT_W-1:0]          credit,
    output logic [CREDIT_W-1:0]          change_due,
    output logic                         vend_pulse,
    output logic [$clog2(NUM_ITEMS)-1:0] vend_item,
    output logic                         error_flag,
    output logic                         coin_reject,
    output logic                         thank_you,
    output logic [2:0]                   state,
    output logic [STOCK_W-1:0]           stock_level,
    output logic [NUM_ITEMS-1:0]         stock_low
);

    localparam int IDX_W = $clog2(NUM_ITEMS);
    localparam int TY_W  = (THANK_YOU_CYCLES > 1) ? $clog2(THANK_YOU_CYCLES) : 1;

    state_t              st;
    logic [IDX_W-1:0]    item_q;
    logic [CREDIT_W-1:0] price_q;
    logic                from_vend_q;
    logic                restock_pend_q;
    logic [TY_W-1:0]     ty_cnt;

    logic [STOCK_W-1:0]  op_level;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] credit_in;
    logic [CREDIT_W-1:0] price_now;
    logic [CREDIT_W-1:0] credit_after_vend;
    logic [CREDIT_W-1:0] coin_pick;
    logic                dec_stb;
    logic                restock_apply;

    assign state = st;

    vend_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT),
        .STOCK_MAX  (STOCK_MAX),
        .LOW_THRESH (LOW_THRESH)
    ) u_stock (
        .clk      (clk),
        .rst      (rst),
        .dec_stb  (dec_stb),
        .op_idx   (item_q),
        .restock  (restock_apply),
        .rd_idx   (item_sel),
        .rd_level (stock_level),
        .op_level (op_level),
        .low      (stock_low)
    );

    // Saturating coin add, low-stock pricing, post-vend credit and greedy change coin
    always_comb begin
        coin_sum          = {1'b0, credit} + {1'b0, coin_value};
        credit_in         = credit;
        if (coin_valid) credit_in = coin_sum[CREDIT_W] ? '1 : coin_sum[CREDIT_W-1:0];
        price_now         = CREDIT_W'(price_of(base_of(2'(item_q)), stock_low[item_q]));
        credit_after_vend = credit - price_q;
        if (credit >= CREDIT_W'(DENOM_HI))       coin_pick = CREDIT_W'(DENOM_HI);
        else if (credit >= CREDIT_W'(DENOM_MID)) coin_pick = CREDIT_W'(DENOM_MID);
        else                                     coin_pick = CREDIT_W'(DENOM_LO);
        // Restock only touches the counters while idle, so it can never meet a vend
        dec_stb           = (st == S_VEND);
        restock_apply     = (st == S_IDLE) && (restock || restock_pend_q);
    end

    // Main FSM with credit, change handshake and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= S_IDLE;
            item_q         <= '0;
            price_q        <= '0;
            from_vend_q    <= 1'b0;
            restock_pend_q <= 1'b0;
            ty_cnt         <= '0;
            credit         <= '0;
            change_due     <= '0;
            chg_valid      <= 1'b0;
            chg_value      <= '0;
            vend_pulse     <= 1'b0;
            vend_item      <= '0;
            error_flag     <= 1'b0;
            coin_reject    <= 1'b0;
            thank_you      <= 1'b0;
        end else begin
            vend_pulse  <= 1'b0;
            error_flag  <= 1'b0;
            coin_reject <= coin_valid && (st != S_IDLE);
            if (st == S_IDLE)  restock_pend_q <= 1'b0;
            else if (restock)  restock_pend_q <= 1'b1;

            case (st)
                S_IDLE: begin
                    credit <= credit_in;
                    if (purchase) begin
                        item_q <= item_sel;
                        st     <= S_CHECK;
                    end else if (cancel && credit_in != '0) begin
                        st <= S_REFUND;
                    end
                end
                S_CHECK: begin
                    price_q <= price_now;
                    if (op_level == '0 || credit < price_now) begin
                        st         <= S_ERROR;
                        error_flag <= 1'b1;
                    end else begin
                        st         <= S_VEND;
                        vend_pulse <= 1'b1;
                        vend_item  <= item_q;
                    end
                end
                S_VEND: begin
                    credit      <= credit_after_vend;
                    change_due  <= credit_after_vend;
                    from_vend_q <= 1'b1;
                    if (credit_after_vend != '0) begin
                        st <= S_CHANGE;
                    end else begin
                        st        <= S_THANK_YOU;
                        thank_you <= 1'b1;
                        ty_cnt    <= '0;
                    end
                end
                S_REFUND: begin
                    change_due  <= credit;
                    from_vend_q <= 1'b0;
                    st          <= S_CHANGE;
                end
                S_CHANGE: begin
                    if (chg_valid && chg_ack) begin
                        chg_valid  <= 1'b0;
                        chg_value  <= '0;
                        credit     <= credit - chg_value;
                        change_due <= change_due - chg_value;
                        if (credit == chg_value) begin
                            if (from_vend_q) begin
                                st        <= S_THANK_YOU;
                                thank_you <= 1'b1;
                                ty_cnt    <= '0;
                            end else begin
                                st <= S_IDLE;
                            end
                        end
                    end else if (!chg_valid) begin
                        chg_valid <= 1'b1;
                        chg_value <= coin_pick;
                    end
                end
                S_THANK_YOU: begin
                    if (ty_cnt == TY_W'(THANK_YOU_CYCLES - 1)) begin
                        thank_you <= 1'b0;
                        st        <= S_IDLE;
                    end else begin
                        ty_cnt <= ty_cnt + TY_W'(1);
                    end
                end
                S_ERROR: begin
                    st <= S_IDLE;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench for vend_ctrl_multi: vector table, directed corner cases, random transactions.
// Latency: n/a.
// Backpressure: the bench drives chg_ack, optionally withholding it to test coin stability.
module tb_vend_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = '0;
    logic       purchase = 1'b0;
    logic       cancel = 1'b0;
    logic [1:0] item_sel = '0;
    logic       restock = 1'b0;
    logic       chg_valid;
    logic [7:0] chg_value;
    logic       chg_ack = 1'b0;
    logic [7:0] credit;
    logic [7:0] change_due;
    logic       vend_pulse;
    logic [1:0] vend_item;
    logic       error_flag;
    logic       coin_reject;
    logic       thank_you;
    logic [2:0] state;
    logic [3:0] stock_level;
    logic [3:0] stock_low;

    vend_ctrl_multi #(
        .NUM_ITEMS(4), .CREDIT_W(8), .STOCK_W(4), .STOCK_INIT(5),
        .STOCK_MAX(15), .LOW_THRESH(2), .THANK_YOU_CYCLES(10)
    ) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .purchase(purchase), .cancel(cancel), .item_sel(item_sel), .restock(restock),
        .chg_valid(chg_valid), .chg_value(chg_value), .chg_ack(chg_ack),
        .credit(credit), .change_due(change_due), .vend_pulse(vend_pulse),
        .vend_item(vend_item), .error_flag(error_flag), .coin_reject(coin_reject),
        .thank_you(thank_you), .state(state), .stock_level(stock_level), .stock_low(stock_low)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: customer-visible quantities only
    int m_credit;
    int m_stock [4];
    int base_tab [4] = '{3, 4, 6, 8};

    typedef struct {
        int c0;
        int c1;
        int item;
        int exp_vend;
        int exp_change;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int m_price(input int i);
        return base_tab[i % 4] + ((m_stock[i] <= 2) ? 1 : 0);
    endfunction

    function automatic int greedy(input int c);
        if (c >= 5) return 5;
        if (c >= 2) return 2;
        return 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_state", state, 0);
        check("rst_credit", credit, 0);
        check("rst_change_due", change_due, 0);
        check("rst_chg_valid", chg_valid, 0);
        check("rst_flags", {vend_pulse, error_flag, coin_reject, thank_you}, 0);
        check("rst_stock", stock_level, 5);
        rst = 1'b0;
        tick();
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 5;
    endtask

    task automatic insert_coin(input int v);
        coin_valid = 1'b1;
        coin_value = 8'(v);
        tick();
        coin_valid = 1'b0;
        m_credit = sat(m_credit + v);
        check("credit_after_coin", credit, m_credit);
    endtask

    task automatic do_restock();
        restock = 1'b1;
        tick();
        restock = 1'b0;
        for (int i = 0; i < 4; i++) m_stock[i] = 15;
        check("restock_level", stock_level, 15);
    endtask

    // Collect change coins until the model's credit is exhausted
    task automatic pay_out(input bit after_vend, input int hold);
        int budget;
        int exp_coin;
        bit first;
        first = 1'b1;
        while (m_credit > 0) begin
            budget = 0;
            while (!chg_valid && budget < 20) begin
                tick();
                budget++;
            end
            if (!chg_valid) begin
                check("chg_timeout", 0, 1);
                return;
            end
            exp_coin = greedy(m_credit);
            check("chg_value", chg_value, exp_coin);
            if (first && hold > 0) begin
                for (int k = 0; k < hold; k++) begin
                    tick();
                    check("chg_hold_valid", chg_valid, 1);
                    check("chg_hold_value", chg_value, exp_coin);
                end
            end
            first = 1'b0;
            chg_ack = 1'b1;
            tick();
            chg_ack = 1'b0;
            m_credit -= exp_coin;
            check("chg_valid_drop", chg_valid, 0);
            check("credit_after_chg", credit, m_credit);
            check("change_due_after_chg", change_due, m_credit);
        end
        check("state_after_change", state, after_vend ? 4 : 0);
    endtask

    task automatic do_purchase(input int item, input int coin, input bit poke,
                               output int got_vend, output int got_change);
        int price;
        int exp_vend;
        int cnt;
        got_vend   = -1;
        got_change = -1;
        item_sel = 2'(item);
        if (coin > 0) begin
            coin_valid = 1'b1;
            coin_value = 8'(coin);
            m_credit = sat(m_credit + coin);
        end
        purchase = 1'b1;
        tick();
        purchase   = 1'b0;
        coin_valid = 1'b0;
        check("state_check", state, 1);
        price    = m_price(item);
        exp_vend = (m_stock[item] > 0 && m_credit >= price) ? 1 : 0;
        tick();
        got_vend = int'(vend_pulse);
        check("vend_pulse", vend_pulse, exp_vend);
        check("error_flag", error_flag, 1 - exp_vend);
        if (int'(vend_pulse) != exp_vend) return;
        if (exp_vend == 0) begin
            check("state_error", state, 5);
            tick();
            check("error_one_cycle", error_flag, 0);
            check("state_after_error", state, 0);
            check("credit_after_error", credit, m_credit);
            check("stock_after_error", stock_level, m_stock[item]);
            return;
        end
        check("vend_item", vend_item, item);
        m_credit -= price;
        m_stock[item] -= 1;
        tick();
        check("vend_one_cycle", vend_pulse, 0);
        check("credit_after_vend", credit, m_credit);
        check("change_due_latched", change_due, m_credit);
        check("stock_after_vend", stock_level, m_stock[item]);
        got_change = int'(change_due);
        if (m_credit > 0) pay_out(1'b1, 0);
        cnt = 0;
        while (thank_you && cnt < 50) begin
            cnt++;
            if (poke && cnt == 2) begin
                coin_valid = 1'b1;
                coin_value = 8'd5;
                restock    = 1'b1;
            end
            if (poke && cnt == 3) begin
                coin_valid = 1'b0;
                restock    = 1'b0;
                for (int i = 0; i < 4; i++) m_stock[i] = 15;
                check("coin_reject_pulse", coin_reject, 1);
                check("credit_on_reject", credit, m_credit);
            end
            tick();
        end
        check("thank_you_cycles", cnt, 10);
        check("state_after_thanks", state, 0);
        if (poke) begin
            tick();
            check("restock_pending_applied", stock_level, 15);
        end
    endtask

    task automatic do_cancel(input int hold);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        if (m_credit > 0) begin
            check("state_refund", state, 6);
            tick();
            check("state_change", state, 3);
            check("refund_change_due", change_due, m_credit);
            pay_out(1'b0, hold);
            check("no_thanks_after_refund", thank_you, 0);
        end else begin
            check("cancel_zero_ignored", state, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int gv;
        int gc;
        int budget;
        int r;

        vecs[0] = '{c0: 5,   c1: 0,  item: 0, exp_vend: 1, exp_change: 2};
        vecs[1] = '{c0: 1,   c1: 0,  item: 2, exp_vend: 0, exp_change: -1};
        vecs[2] = '{c0: 4,   c1: 0,  item: 1, exp_vend: 1, exp_change: 0};
        vecs[3] = '{c0: 6,   c1: 2,  item: 3, exp_vend: 1, exp_change: 0};
        vecs[4] = '{c0: 5,   c1: 2,  item: 2, exp_vend: 1, exp_change: 1};
        vecs[5] = '{c0: 250, c1: 10, item: 0, exp_vend: 1, exp_change: 252};
        vecs[6] = '{c0: 0,   c1: 0,  item: 1, exp_vend: 0, exp_change: -1};
        vecs[7] = '{c0: 10,  c1: 0,  item: 3, exp_vend: 1, exp_change: 2};

        // Single-purchase vectors, each from a fresh reset
        for (int v = 0; v < 8; v++) begin
            do_reset();
            if (vecs[v].c0 > 0) insert_coin(vecs[v].c0);
            if (vecs[v].c1 > 0) insert_coin(vecs[v].c1);
            do_purchase(vecs[v].item, 0, 1'b0, gv, gc);
            check($sformatf("vec%0d_vend", v), gv, vecs[v].exp_vend);
            check($sformatf("vec%0d_change", v), gc, vecs[v].exp_change);
        end

        // Refund of 8 with the first coin's ack withheld
        do_reset();
        insert_coin(5);
        insert_coin(2);
        insert_coin(1);
        do_cancel(3);
        check("refund_credit_zero", credit, 0);

        // Deplete item1: price rises to 5 once stock is low
        do_reset();
        while (m_stock[1] > 2) begin
            insert_coin(m_price(1));
            do_purchase(1, 0, 1'b0, gv, gc);
        end
        check("low_stock_level", stock_level, 2);
        check("low_flag_item1", stock_low[1], 1);
        insert_coin(4);
        do_purchase(1, 0, 1'b0, gv, gc);
        check("low_price_4_rejected", gv, 0);
        insert_coin(1);
        do_purchase(1, 0, 1'b0, gv, gc);
        check("low_price_5_accepted", gv, 1);
        insert_coin(5);
        do_purchase(1, 0, 1'b0, gv, gc);
        check("last_item_vend", gv, 1);
        check("empty_stock", stock_level, 0);
        insert_coin(6);
        do_purchase(1, 0, 1'b0, gv, gc);
        check("empty_stock_error", gv, 0);
        do_restock();
        check("low_flag_cleared", stock_low[1], 0);

        // Coin during THANK_YOU is rejected; coin with purchase counts toward CHECK
        do_reset();
        insert_coin(2);
        do_purchase(0, 1, 1'b1, gv, gc);
        check("coin_with_purchase_vend", gv, 1);

        // Asynchronous reset in the middle of a change handshake
        do_reset();
        insert_coin(5);
        item_sel = 2'd0;
        purchase = 1'b1;
        tick();
        purchase = 1'b0;
        budget = 0;
        while (!chg_valid && budget < 20) begin
            tick();
            budget++;
        end
        check("chg_valid_before_rst", chg_valid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_chg_valid", chg_valid, 0);
        check("async_rst_state", state, 0);
        check("async_rst_credit", credit, 0);
        check("async_rst_change_due", change_due, 0);
        check("async_rst_stock", stock_level, 5);
        #3;
        rst = 1'b0;
        tick();
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 5;

        // Random transactions against the model
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                case ($urandom_range(0, 3))
                    0:       insert_coin(1);
                    1:       insert_coin(2);
                    2:       insert_coin(5);
                    default: insert_coin(10);
                endcase
            end else if (r <= 6) begin
                do_purchase($urandom_range(0, 3),
                            ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b0, gv, gc);
            end else if (r <= 8) begin
                do_cancel($urandom_range(0, 2));
            end else begin
                do_restock();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
